// File: rtl/reg_wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter: request record and
// the upstream protocol check used at the arbiter boundary.
`ifndef REG_WB_ARB_PKG_SV
`define REG_WB_ARB_PKG_SV

// A source may only present a result while the arbiter is not stalling it.
`define WB_PROTO_CHECK(clk_s, rst_s, stall_s, valid_s) assert property (@(posedge clk_s) disable iff (rst_s) !((stall_s) && (valid_s)));

package reg_wb_arb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

`endif

// File: rtl/reg_wb_arb_fifo.sv
// Pending-write queue: up to two pushes and one pop per cycle, with every
// entry exposed in age order so the forward search can scan it.
module wb_req_fifo
   import reg_wb_arb_pkg::*;
#(
   parameter int Q_DEPTH = 4,
   localparam int PW = $clog2(Q_DEPTH),
   localparam int CW = $clog2(Q_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push0_v_i,
   input  wb_req_t                  push0_i,
   input  logic                     push1_v_i,
   input  wb_req_t                  push1_i,
   input  logic                     pop_i,
   output logic [CW-1:0]            occ_o,
   output wb_req_t [Q_DEPTH-1:0]    ent_o
);

   wb_req_t       mem_q [Q_DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr1;
   logic [CW-1:0] occ_q, occ_d;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr1   = ptr_inc(wr_q);
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push0_v_i) wr_d = push1_v_i ? ptr_inc(wr1) : wr1;
      if (pop_i)     rd_d = ptr_inc(rd_q);
      occ_d = occ_q + CW'(push0_v_i) + CW'(push1_v_i) - CW'(pop_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         occ_q <= occ_d;
      end
   end

   // push1 is only ever used together with push0, so it lands one slot later.
   always_ff @(posedge clk) begin
      if (push0_v_i) mem_q[wr_q] <= push0_i;
      if (push1_v_i) mem_q[wr1]  <= push1_i;
   end

   always_comb begin
      for (int i = 0; i < Q_DEPTH; i++) begin
         ent_o[i] = mem_q[PW'((int'(rd_q) + i) % Q_DEPTH)];
      end
   end

   assign occ_o = occ_q;

endmodule

// File: rtl/reg_wb_arb.sv
// Writeback arbiter: merges load and ALU results onto the single register
// file write port, queues the overflow in order and forwards pending values.
module reg_wb_arb
   import reg_wb_arb_pkg::*;
#(
   parameter int Q_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              stall,
   output logic              w_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic [ADDR_W-1:0] rn_addr,
   input  logic [ADDR_W-1:0] rm_addr,
   output logic              rn_fwd_hit,
   output logic [DATA_W-1:0] rn_fwd_data,
   output logic              rm_fwd_hit,
   output logic [DATA_W-1:0] rm_fwd_data
);

   localparam int CW = $clog2(Q_DEPTH + 1);

   wb_req_t                mem_req, alu_req, sel, push0, push1;
   wb_req_t [Q_DEPTH-1:0]  ent;
   logic [CW-1:0]          occ;
   logic                   mem_v, alu_v, head_v, sel_v, push0_v, push1_v, pop;
   logic                   stall_q, stall_d;

   assign mem_req = '{addr: mem_rd, data: mem_data};
   assign alu_req = '{addr: alu_rd, data: alu_data};
   assign mem_v   = mem_valid & ~rst;
   assign alu_v   = alu_valid & ~rst;
   assign head_v  = (occ != '0) & ~rst;

   wb_req_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push0_v_i (push0_v),
      .push0_i   (push0),
      .push1_v_i (push1_v),
      .push1_i   (push1),
      .pop_i     (pop),
      .occ_o     (occ),
      .ent_o     (ent)
   );

   // Oldest request wins the port; the rest are queued mem before alu.
   always_comb begin
      sel     = '0;
      sel_v   = 1'b0;
      pop     = 1'b0;
      push0_v = 1'b0;
      push1_v = 1'b0;
      push0   = mem_req;
      push1   = alu_req;
      if (head_v) begin
         sel     = ent[0];
         sel_v   = 1'b1;
         pop     = 1'b1;
         push0_v = mem_v | alu_v;
         push0   = mem_v ? mem_req : alu_req;
         push1_v = mem_v & alu_v;
      end else if (mem_v) begin
         sel     = mem_req;
         sel_v   = 1'b1;
         push0_v = alu_v;
         push0   = alu_req;
      end else if (alu_v) begin
         sel     = alu_req;
         sel_v   = 1'b1;
      end
   end

   assign w_en    = sel_v;
   assign rd_addr = sel.addr;
   assign rd_data = sel.data;

   // Threshold at Q_DEPTH-1 leaves room for one more cycle of dual arrivals.
   always_comb stall_d = (int'(occ) + int'(push0_v) + int'(push1_v) - int'(pop)) >= (Q_DEPTH - 1);

   always_ff @(posedge clk) begin
      if (rst) stall_q <= 1'b0;
      else     stall_q <= stall_d;
   end

   assign stall = stall_q;

   // Scan oldest to youngest so the last match is the youngest value.
   always_comb begin
      rn_fwd_hit  = 1'b0;
      rn_fwd_data = '0;
      rm_fwd_hit  = 1'b0;
      rm_fwd_data = '0;
      if (sel_v && sel.addr == rn_addr) begin rn_fwd_hit = 1'b1; rn_fwd_data = sel.data; end
      if (sel_v && sel.addr == rm_addr) begin rm_fwd_hit = 1'b1; rm_fwd_data = sel.data; end
      for (int i = 0; i < Q_DEPTH; i++) begin
         if (head_v && i < int'(occ)) begin
            if (ent[i].addr == rn_addr) begin rn_fwd_hit = 1'b1; rn_fwd_data = ent[i].data; end
            if (ent[i].addr == rm_addr) begin rm_fwd_hit = 1'b1; rm_fwd_data = ent[i].data; end
         end
      end
      if (mem_v && mem_rd == rn_addr) begin rn_fwd_hit = 1'b1; rn_fwd_data = mem_data; end
      if (mem_v && mem_rd == rm_addr) begin rm_fwd_hit = 1'b1; rm_fwd_data = mem_data; end
      if (alu_v && alu_rd == rn_addr) begin rn_fwd_hit = 1'b1; rn_fwd_data = alu_data; end
      if (alu_v && alu_rd == rm_addr) begin rm_fwd_hit = 1'b1; rm_fwd_data = alu_data; end
   end

   `WB_PROTO_CHECK(clk, rst, stall_q, mem_valid | alu_valid)

endmodule

// File: tb/tb_reg_wb_arb.sv
// Bench for reg_wb_arb: directed vector table, reset-mid-drain sequence and
// random traffic against an in-order pending-write queue model.
module tb_reg_wb_arb;
   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0, alu_valid = 1'b0;
   logic [3:0]  mem_rd = '0, alu_rd = '0, rn_addr = '0, rm_addr = '0;
   logic [31:0] mem_data = '0, alu_data = '0;
   logic        stall, w_en, rn_fwd_hit, rm_fwd_hit;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data, rn_fwd_data, rm_fwd_data;

   always #5 clk = ~clk;

   reg_wb_arb #(.Q_DEPTH(QD)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .stall(stall), .w_en(w_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rn_addr(rn_addr), .rm_addr(rm_addr),
      .rn_fwd_hit(rn_fwd_hit), .rn_fwd_data(rn_fwd_data),
      .rm_fwd_hit(rm_fwd_hit), .rm_fwd_data(rm_fwd_data)
   );

   typedef struct { logic [3:0] addr; logic [31:0] data; } req_t;

   typedef struct {
      logic mv; logic [3:0] mr; logic [31:0] md;
      logic av; logic [3:0] ar; logic [31:0] ad;
      logic [3:0] rn;
      logic e_wen; logic [3:0] e_addr; logic [31:0] e_data;
      logic e_hit; logic [31:0] e_fwd; logic e_stall;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   req_t        mq[$];
   logic [31:0] rf[16];
   logic [31:0] arch[16];
   logic        exp_stall = 1'b0;
   vec_t        tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive after the edge, compare at the falling edge against the queue model.
   task automatic step(input logic r, input logic mv, input logic [3:0] mr, input logic [31:0] md,
                       input logic av, input logic [3:0] ar, input logic [31:0] ad,
                       input logic [3:0] rn, input logic [3:0] rm);
      req_t        cand[$];
      logic [31:0] na[16];
      logic        eh_n, eh_m;
      logic [31:0] ed_n, ed_m;
      @(posedge clk);
      #1;
      if (stall === 1'b1) begin mv = 1'b0; av = 1'b0; end
      rst = r; mem_valid = mv; mem_rd = mr; mem_data = md;
      alu_valid = av; alu_rd = ar; alu_data = ad; rn_addr = rn; rm_addr = rm;
      @(negedge clk);
      chk("stall", 32'(stall), 32'(exp_stall));
      if (r) begin
         chk("w_en_in_reset", 32'(w_en), 32'd0);
         mq.delete();
         exp_stall = 1'b0;
         arch = rf;
      end else begin
         cand = mq;
         if (mv) cand.push_back('{mr, md});
         if (av) cand.push_back('{ar, ad});
         chk("w_en", 32'(w_en), 32'(cand.size() > 0));
         if (cand.size() > 0) begin
            chk("rd_addr", 32'(rd_addr), 32'(cand[0].addr));
            chk("rd_data", rd_data, cand[0].data);
         end else begin
            chk("rd_addr_idle", 32'(rd_addr), 32'd0);
            chk("rd_data_idle", rd_data, 32'd0);
         end
         eh_n = 1'b0; ed_n = '0; eh_m = 1'b0; ed_m = '0;
         foreach (cand[i]) begin
            if (cand[i].addr == rn) begin eh_n = 1'b1; ed_n = cand[i].data; end
            if (cand[i].addr == rm) begin eh_m = 1'b1; ed_m = cand[i].data; end
         end
         chk("rn_hit", 32'(rn_fwd_hit), 32'(eh_n));
         chk("rn_fwd", rn_fwd_data, ed_n);
         chk("rm_hit", 32'(rm_fwd_hit), 32'(eh_m));
         chk("rm_fwd", rm_fwd_data, ed_m);
         na = arch;
         if (mv) na[mr] = md;
         if (av) na[ar] = ad;
         chk("rn_read", rn_fwd_hit ? rn_fwd_data : rf[rn], na[rn]);
         chk("rm_read", rm_fwd_hit ? rm_fwd_data : rf[rm], na[rm]);
         arch = na;
         if (w_en) rf[rd_addr] = rd_data;
         mq = cand;
         if (mq.size() > 0) void'(mq.pop_front());
         exp_stall = (mq.size() >= QD - 1);
      end
   endtask

   task automatic idle(input logic [3:0] rn);
      step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, rn, rn);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin rf[i] = '0; arch[i] = '0; end

      //             mv  mr    md         av  ar    ad         rn   | wen addr  data      hit fwd       stall
      tbl[0]  = '{1'b0, 4'd0, 32'h0,   1'b1, 4'd3, 32'h11,  4'd3, 1'b1, 4'd3, 32'h11,  1'b1, 32'h11,  1'b0};
      tbl[1]  = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd3, 1'b0, 4'd0, 32'h0,   1'b0, 32'h0,   1'b0};
      tbl[2]  = '{1'b1, 4'd2, 32'hAA,  1'b1, 4'd5, 32'hBB,  4'd5, 1'b1, 4'd2, 32'hAA,  1'b1, 32'hBB,  1'b0};
      tbl[3]  = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd5, 1'b1, 4'd5, 32'hBB,  1'b1, 32'hBB,  1'b0};
      tbl[4]  = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd5, 1'b0, 4'd0, 32'h0,   1'b0, 32'h0,   1'b0};
      tbl[5]  = '{1'b1, 4'd7, 32'h1,   1'b1, 4'd7, 32'h2,   4'd7, 1'b1, 4'd7, 32'h1,   1'b1, 32'h2,   1'b0};
      tbl[6]  = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd7, 1'b1, 4'd7, 32'h2,   1'b1, 32'h2,   1'b0};
      tbl[7]  = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd7, 1'b0, 4'd0, 32'h0,   1'b0, 32'h0,   1'b0};
      tbl[8]  = '{1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102, 4'd2, 1'b1, 4'd1, 32'h101, 1'b1, 32'h102, 1'b0};
      tbl[9]  = '{1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104, 4'd3, 1'b1, 4'd2, 32'h102, 1'b1, 32'h103, 1'b0};
      tbl[10] = '{1'b1, 4'd5, 32'h105, 1'b1, 4'd6, 32'h106, 4'd6, 1'b1, 4'd3, 32'h103, 1'b1, 32'h106, 1'b0};
      tbl[11] = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd4, 1'b1, 4'd4, 32'h104, 1'b1, 32'h104, 1'b1};
      tbl[12] = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd6, 1'b1, 4'd5, 32'h105, 1'b1, 32'h106, 1'b0};
      tbl[13] = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd6, 1'b1, 4'd6, 32'h106, 1'b1, 32'h106, 1'b0};
      tbl[14] = '{1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 32'h0,   4'd6, 1'b0, 4'd0, 32'h0,   1'b0, 32'h0,   1'b0};

      step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
      idle(4'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_w_en", 32'(w_en), 32'd0);

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].av, tbl[i].ar, tbl[i].ad,
              tbl[i].rn, tbl[i].rn);
         chk($sformatf("tbl%0d_wen", i), 32'(w_en), 32'(tbl[i].e_wen));
         chk($sformatf("tbl%0d_addr", i), 32'(rd_addr), 32'(tbl[i].e_addr));
         chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_rn_hit", i), 32'(rn_fwd_hit), 32'(tbl[i].e_hit));
         chk($sformatf("tbl%0d_rn_fwd", i), rn_fwd_data, tbl[i].e_fwd);
         chk($sformatf("tbl%0d_rm_fwd", i), rm_fwd_data, tbl[i].e_fwd);
         chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      end

      // Reset while three writes are still queued: they are dropped.
      step(1'b0, 1'b1, 4'd8,  32'h208, 1'b1, 4'd9,  32'h209, 4'd0, 4'd0);
      step(1'b0, 1'b1, 4'd10, 32'h20A, 1'b1, 4'd11, 32'h20B, 4'd0, 4'd0);
      step(1'b0, 1'b1, 4'd12, 32'h20C, 1'b1, 4'd13, 32'h20D, 4'd0, 4'd0);
      step(1'b1, 1'b0, 4'd0,  32'd0,   1'b0, 4'd0,  32'd0,   4'd13, 4'd11);
      step(1'b0, 1'b0, 4'd0,  32'd0,   1'b0, 4'd0,  32'd0,   4'd13, 4'd11);
      chk("post_rst_w_en", 32'(w_en), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd0);
      chk("post_rst_rn_hit", 32'(rn_fwd_hit), 32'd0);
      chk("post_rst_rm_hit", 32'(rm_fwd_hit), 32'd0);
      step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h55, 4'd9, 4'd9);
      chk("post_rst_alu_wen", 32'(w_en), 32'd1);
      chk("post_rst_alu_addr", 32'(rd_addr), 32'd9);
      chk("post_rst_alu_data", rd_data, 32'h55);

      for (int n = 0; n < 600; n++) begin
         logic [3:0] a0, a1, b0, b1;
         a0 = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         a1 = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         b0 = 4'($urandom_range(0, 3));
         b1 = 4'($urandom_range(0, 15));
         step(($urandom % 97) == 0, 1'($urandom % 2), a0, $urandom,
              1'($urandom % 2), a1, $urandom, b0, b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
